// File: rtl/matrix_loader.sv
// matrix_loader: feed stage for the matrix coprocessor.
// Streams 8-bit elements in over a valid/ready handshake and writes two
// MAX_DIM x MAX_DIM operand matrices (A, then B) row-major into the
// coprocessor memory. Locations outside the active n x n window are
// zero-filled, so every load issues 2*MAX_DIM*MAX_DIM writes.
//
// Ports
//   clk       clock, all logic on posedge
//   reset_n   synchronous active-low reset
//   start     load request, sampled only while idle
//   tamanho   active dimension n (1..MAX_DIM), sampled with start
//   in_data   element value
//   in_valid  in_data is valid
//   in_ready  element accepted when in_valid & in_ready (combinational)
//   wr_en     memory write strobe
//   wr_sel    0 = matrix A, 1 = matrix B
//   wr_addr   row*MAX_DIM + col
//   wr_data   value to write
//   busy      load in progress
//   done      pulse coincident with the final write of B
//   err       pulse when start arrives with an out-of-range tamanho
module matrix_loader #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_DIM = 5,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        tamanho,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int unsigned DIM_W = 3;
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(MAX_DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_A = 2'd1,
        S_LOAD_B = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   row_q,     row_d;
    logic [CNT_W-1:0]   col_q,     col_d;
    logic [DIM_W-1:0]   n_q,       n_d;
    logic               wr_en_q,   wr_en_d;
    logic               wr_sel_q,  wr_sel_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               err_q,     err_d;

    logic loading_c;
    logic in_window_c;
    logic advance_c;
    logic last_pos_c;
    logic dim_ok_c;

    // Position decode shared by the handshake and the next-state logic.
    always_comb begin
        loading_c   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
        in_window_c = (32'(row_q) < 32'(n_q)) && (32'(col_q) < 32'(n_q));
        // Out-of-window positions never wait for the stream.
        advance_c   = loading_c && (!in_window_c || in_valid);
        last_pos_c  = (row_q == LAST_POS) && (col_q == LAST_POS);
        dim_ok_c    = (tamanho != '0) && (32'(tamanho) <= MAX_DIM);
    end

    assign in_ready = loading_c && in_window_c;

    // Next-state, position counters and write-port staging.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        n_d       = n_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dim_ok_c) begin
                        n_d     = tamanho;
                        row_d   = '0;
                        col_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_LOAD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LOAD_A, S_LOAD_B: begin
                if (advance_c) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = (state_q == S_LOAD_B);
                    wr_addr_d = ADDR_W'(32'(row_q) * MAX_DIM + 32'(col_q));
                    wr_data_d = in_window_c ? in_data : '0;

                    if (last_pos_c) begin
                        row_d = '0;
                        col_d = '0;
                        if (state_q == S_LOAD_A) begin
                            state_d = S_LOAD_B;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else if (col_q == LAST_POS) begin
                        col_d = '0;
                        row_d = row_q + CNT_W'(1);
                    end else begin
                        col_d = col_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            n_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            n_q       <= n_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: the stimulus side pushes the expected
// write sequence, a negedge monitor pops and compares every write.
module tb_matrix_loader;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MAX_DIM = 5;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DEPTH   = MAX_DIM * MAX_DIM;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [2:0]        tamanho;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;

    matrix_loader #(
        .DATA_W (DATA_W),
        .MAX_DIM(MAX_DIM),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .tamanho (tamanho),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    typedef struct packed {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              done;
    } exp_t;

    exp_t sb[$];
    int   errors     = 0;
    int   checks     = 0;
    int   done_cnt   = 0;
    int   acc_cnt    = 0;
    logic prev_stall = 1'b0;
    time  start_time = 0;
    time  done_time  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every write against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (prev_stall) chk("stall_wr_en", 32'(wr_en), 32'd0);
        prev_stall = in_ready && !in_valid;
        if (in_valid && in_ready) acc_cnt++;
        if (wr_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d sel %0d, expected none", wr_addr, wr_sel);
            end else begin
                e = sb.pop_front();
                chk("wr_sel",  32'(wr_sel),  32'(e.sel));
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("done",    32'(done),    32'(e.done));
                chk("busy",    32'(busy),    32'(!e.done));
            end
        end else if (done) begin
            checks++;
            errors++;
            $display("FAIL done_without_write: got done=1 expected 0");
        end
        if (done) begin
            done_cnt++;
            done_time = $time;
        end
    end

    // Reference model: full write sequence for an n x n load, first 'limit' entries.
    task automatic push_expect(input int n, input int ba, input int bb, input int limit);
        int k = 0;
        int idx = 0;
        exp_t e;
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < int'(MAX_DIM); r++) begin
                for (int c = 0; c < int'(MAX_DIM); c++) begin
                    e.sel  = (m == 1);
                    e.addr = ADDR_W'(r * int'(MAX_DIM) + c);
                    if (r < n && c < n) begin
                        e.data = DATA_W'((m == 0) ? ba + idx : bb + idx - n * n);
                        idx++;
                    end else begin
                        e.data = '0;
                    end
                    e.done = (k == 2 * int'(DEPTH) - 1);
                    if (k < limit) sb.push_back(e);
                    k++;
                end
            end
        end
    endtask

    task automatic do_start(input logic [2:0] t);
        @(posedge clk);
        #1;
        start   = 1'b1;
        tamanho = t;
        @(posedge clk);
        start_time = $time;
        #1;
        start = 1'b0;
    endtask

    // Stream driver: returns at posedge+1 after max_iter cycles or once all elements are accepted.
    task automatic feed(input int n, input int ba, input int bb, input bit toggle,
                        input int max_iter, input bit mid_start);
        int  idx = 0;
        int  it = 0;
        bit  phase = 1'b0;
        bit  acc;
        int  nn = n * n;
        while (idx < 2 * nn && it < max_iter) begin
            in_valid = toggle ? !phase : 1'b1;
            in_data  = DATA_W'((idx < nn) ? ba + idx : bb + idx - nn);
            if (mid_start && it == 5) begin
                start   = 1'b1;
                tamanho = 3'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            phase = !phase;
            it++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
        chk({tag, "_wr_sel"},   32'(wr_sel),   32'd0);
        chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
        chk({tag, "_wr_data"},  32'(wr_data),  32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int d0;
        reset_n  = 1'b0;
        start    = 1'b0;
        tamanho  = '0;
        in_data  = '0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1: n=5, no stalls, 1..50, done 50 cycles after start
        push_expect(5, 1, 26, 50);
        d0 = done_cnt;
        do_start(3'd5);
        feed(5, 1, 26, 1'b0, 200, 1'b0);
        wait_done(d0);
        chk("t1_done_latency", 32'(done_time - start_time), 32'(50 * 10 + 5));

        // 2: n=2, zero fill, exactly 8 accepts
        push_expect(2, 10, 20, 50);
        acc_cnt = 0;
        d0 = done_cnt;
        do_start(3'd2);
        feed(2, 10, 20, 1'b0, 200, 1'b0);
        wait_done(d0);
        chk("t2_accepts", 32'(acc_cnt), 32'd8);

        // 3: n=3, in_valid toggling
        push_expect(3, 100, 150, 50);
        acc_cnt = 0;
        d0 = done_cnt;
        do_start(3'd3);
        feed(3, 100, 150, 1'b1, 200, 1'b0);
        wait_done(d0);
        chk("t3_accepts", 32'(acc_cnt), 32'd18);

        // 4: invalid dimensions pulse err and stay idle
        in_valid = 1'b1;
        do_start(3'd0);
        @(negedge clk);
        chk("t4_err_0", 32'(err), 32'd1);
        chk("t4_busy_0", 32'(busy), 32'd0);
        chk("t4_wr_en_0", 32'(wr_en), 32'd0);
        chk("t4_in_ready_0", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t4_err_clear_0", 32'(err), 32'd0);
        do_start(3'd6);
        @(negedge clk);
        chk("t4_err_6", 32'(err), 32'd1);
        chk("t4_busy_6", 32'(busy), 32'd0);
        chk("t4_in_ready_6", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t4_err_clear_6", 32'(err), 32'd0);
        chk("t4_wr_en_idle", 32'(wr_en), 32'd0);
        in_valid = 1'b0;

        // 5: reset at the 7th write of B, then a fresh full load
        push_expect(5, 1, 26, int'(DEPTH) + 7);
        d0 = done_cnt;
        do_start(3'd5);
        feed(5, 1, 26, 1'b0, 32, 1'b0);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t5_abort");
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_done", 32'(done_cnt), 32'(d0));
        push_expect(5, 200, 60, 50);
        d0 = done_cnt;
        do_start(3'd5);
        feed(5, 200, 60, 1'b0, 200, 1'b0);
        wait_done(d0);

        // 6: start during a load is ignored
        push_expect(4, 30, 90, 50);
        d0 = done_cnt;
        do_start(3'd4);
        feed(4, 30, 90, 1'b0, 200, 1'b1);
        wait_done(d0);
        chk("t6_busy_end", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
